counter: RTL and testbench

//   Parameterised synchronous up-counter with parallel load, count enable and

---
 rtl/counter.sv | 40 ++++
 tb/tb_counter.sv | 111 +++++++++++
 2 files changed

// File: rtl/counter.sv
// Program-counter register: unsigned WIDTH-bit up-counter with parallel load,
// count enable and asynchronous active-low clear.
module counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;

    // Next-state selection: a jump target beats counting, otherwise hold
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (load) begin
            w_cnt_nxt = cnt_in;
        end else if (enab) begin
            w_cnt_nxt = r_cnt + WIDTH'(1'b1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // State register; clear acts immediately, independent of the clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= {WIDTH{1'b0}};
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign cnt_out = r_cnt;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter (WIDTH=5): inputs driven on the falling edge,
// cnt_out checked against literal values and a running arithmetic model.
module tb_counter;

    localparam int W   = 5;
    localparam int MOD = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic         enab = 1'b0;
    logic [W-1:0] cnt_in = 5'd0;
    logic [W-1:0] cnt_out;

    int checks   = 0;
    int failures = 0;
    int model_val = 0;
    bit model_ok  = 1'b0;

    counter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .enab   (enab),
        .cnt_in (cnt_in),
        .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    // Reference: value the program counter must hold, as plain modular arithmetic
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_val = 0;
            model_ok  = 1'b1;
        end else if (model_ok) begin
            if (load)
                model_val = int'(cnt_in);
            else if (enab)
                model_val = (model_val + 1) % MOD;
        end
    end

    // Every falling edge once reset has been seen, output must match the model
    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if ($isunknown(cnt_out) || int'(cnt_out) != model_val) begin
                failures++;
                $display("FAIL model_cmp t=%0t got=%0h exp=%0h", $time, cnt_out, model_val);
            end
        end
    end

    task automatic chk(input string name, input int exp);
        checks++;
        if ($isunknown(cnt_out) || int'(cnt_out) != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, cnt_out, exp);
        end
    endtask

    // Drive at the current falling edge, then check at the next one
    task automatic dc(input logic l, input logic e, input int din, input int exp, input string name);
        load   = l;
        enab   = e;
        cnt_in = W'(din);
        @(negedge clk);
        chk(name, exp);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", 0);
        rst = 1'b1;

        // 1. loads
        dc(1'b1, 1'b1, 'h15, 'h15, "load_15");
        dc(1'b1, 1'b1, 'h0A, 'h0A, "load_0A");
        dc(1'b1, 1'b1, 'h1F, 'h1F, "load_1F");

        // 2. async clear between edges, held across an edge with load active
        #2 rst = 1'b0;
        #1 chk("async_clear", 0);
        load = 1'b1; cnt_in = 5'h1F; enab = 1'b1;
        @(negedge clk);
        chk("hold_in_reset", 0);

        // 3. release, load, wrap
        rst = 1'b1;
        dc(1'b1, 1'b0, 'h1F, 'h1F, "release_load_1F");
        dc(1'b0, 1'b1, 0, 'h00, "wrap_to_0");
        dc(1'b0, 1'b1, 0, 'h01, "count_01");

        // 4. hold
        for (int i = 0; i < 3; i++) dc(1'b0, 1'b0, 'h1A, 'h01, "hold_01");

        // 5. load priority over enable
        dc(1'b1, 1'b1, 'h07, 'h07, "prio_load_07");
        dc(1'b0, 1'b1, 'h13, 'h08, "resume_08");

        // 6. full count run with wrap
        dc(1'b1, 1'b0, 'h00, 'h00, "load_00");
        for (int i = 1; i <= 32; i++) dc(1'b0, 1'b1, 'h11, i % MOD, "count_run");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
